// File: rtl/reg_bank.sv
// reg_bank: 32 x DATA_W register file, two bypassed combinational read ports, one registered debug port.
// Latency: rs/rt 0 cycles, dbg 1 cycle; no backpressure (every write accepted, reads always valid).
module reg_bank #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        rs_addr,
  input  logic [4:0]        rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              link_en,
  input  logic [DATA_W-1:0] link_data,
  input  logic [4:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam logic [4:0] LINK_REG = 5'd31;

  logic [DATA_W-1:0] regs_q [0:NREG-1];
  logic [DATA_W-1:0] regs_d [0:NREG-1];
  logic [DATA_W-1:0] dbg_data_q;
  logic [DATA_W-1:0] dbg_data_d;

  // Link is applied first so a primary write to R31 overrides it.
  always_comb begin
    regs_d = regs_q;
    if (link_en) regs_d[LINK_REG] = link_data;
    if (wr_en)   regs_d[wr_addr]  = wr_data;
  end

  // Debug port samples pre-write contents: no bypass by design.
  always_comb begin
    dbg_data_d = regs_q[dbg_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      dbg_data_q <= '0;
    end else begin
      regs_q     <= regs_d;
      dbg_data_q <= dbg_data_d;
    end
  end

  always_comb begin
    rs_data = regs_q[rs_addr];
    if (rst)                                 rs_data = '0;
    else if (wr_en && wr_addr == rs_addr)    rs_data = wr_data;
    else if (link_en && rs_addr == LINK_REG) rs_data = link_data;
  end

  always_comb begin
    rt_data = regs_q[rt_addr];
    if (rst)                                 rt_data = '0;
    else if (wr_en && wr_addr == rt_addr)    rt_data = wr_data;
    else if (link_en && rt_addr == LINK_REG) rt_data = link_data;
  end

  assign dbg_data = dbg_data_q;

endmodule

// File: tb/tb_reg_bank.sv
// Bench for reg_bank: directed scenarios plus a randomized run against a reference register model.
module tb_reg_bank;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs_addr, rt_addr, wr_addr, dbg_addr;
  logic [31:0] rs_data, rt_data, dbg_data, wr_data, link_data;
  logic        wr_en, link_en;

  int total = 0;
  int bad   = 0;

  logic [31:0] mdl [32];
  logic [31:0] exp_q [$];
  logic [31:0] expv;

  reg_bank #(.DATA_W(32), .NREG(32)) dut (
    .clk(clk), .rst(rst),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .link_en(link_en), .link_data(link_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Reference view of a combinational read with the inputs currently driven.
  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (rst) return 32'h0;
    if (wr_en && wr_addr == a) return wr_data;
    if (link_en && a == 5'd31) return link_data;
    return mdl[a];
  endfunction

  // Commits the driven inputs into the model, then advances past the next rising edge.
  task automatic clock_edge();
    if (rst) begin
      for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    end else begin
      if (link_en) mdl[31] = link_data;
      if (wr_en)   mdl[wr_addr] = wr_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; link_en = 1'b0; wr_addr = '0; wr_data = '0; link_data = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rs_addr = 5'd0; rt_addr = 5'd31; dbg_addr = 5'd3;
    #1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    expv = exp_q.pop_front(); total++;
    if (rs_data !== expv) begin bad++; $display("FAIL reset_rs got=%h exp=%h", rs_data, expv); end
    expv = exp_q.pop_front(); total++;
    if (rt_data !== expv) begin bad++; $display("FAIL reset_rt got=%h exp=%h", rt_data, expv); end
    expv = exp_q.pop_front(); total++;
    if (dbg_data !== expv) begin bad++; $display("FAIL reset_dbg got=%h exp=%h", dbg_data, expv); end
    // Write and bypass are both suppressed while reset is held.
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_0000;
    #1;
    exp_q.push_back(32'h0);
    expv = exp_q.pop_front(); total++;
    if (rs_data !== expv) begin bad++; $display("FAIL reset_no_bypass got=%h exp=%h", rs_data, expv); end
    clock_edge();
    @(negedge clk);
    rst = 1'b0; idle();
    #1;
    exp_q.push_back(32'h0);
    expv = exp_q.pop_front(); total++;
    if (rs_data !== expv) begin bad++; $display("FAIL reset_write_ignored got=%h exp=%h", rs_data, expv); end
    // Store R5 then apply reset mid-cycle with no clock edge.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
    clock_edge();
    @(negedge clk);
    idle(); rs_addr = 5'd5; dbg_addr = 5'd5;
    #1;
    exp_q.push_back(32'hDEAD_BEEF);
    expv = exp_q.pop_front(); total++;
    if (rs_data !== expv) begin bad++; $display("FAIL r5_stored got=%h exp=%h", rs_data, expv); end
    clock_edge();
    exp_q.push_back(32'hDEAD_BEEF);
    expv = exp_q.pop_front(); total++;
    if (dbg_data !== expv) begin bad++; $display("FAIL r5_dbg got=%h exp=%h", dbg_data, expv); end
    #2 rst = 1'b1;
    #1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    expv = exp_q.pop_front(); total++;
    if (rs_data !== expv) begin bad++; $display("FAIL async_reset_rs got=%h exp=%h", rs_data, expv); end
    expv = exp_q.pop_front(); total++;
    if (dbg_data !== expv) begin bad++; $display("FAIL async_reset_dbg got=%h exp=%h", dbg_data, expv); end
    clock_edge();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_write_collision();
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55; rs_addr = 5'd9;
    #3 rst = 1'b1;
    clock_edge();
    @(negedge clk);
    rst = 1'b0; idle();
    #1;
    exp_q.push_back(32'h0);
    expv = exp_q.pop_front(); total++;
    if (rs_data !== expv) begin bad++; $display("FAIL reset_wins got=%h exp=%h", rs_data, expv); end
    // First edge after release performs a normal write.
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h77;
    clock_edge();
    @(negedge clk);
    idle();
    #1;
    exp_q.push_back(32'h77);
    expv = exp_q.pop_front(); total++;
    if (rs_data !== expv) begin bad++; $display("FAIL first_edge_write got=%h exp=%h", rs_data, expv); end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1234_5678;
    clock_edge();
    @(negedge clk);
    idle(); rs_addr = 5'd7; rt_addr = 5'd7;
    #1;
    exp_q.push_back(32'h1234_5678); exp_q.push_back(32'h1234_5678);
    expv = exp_q.pop_front(); total++;
    if (rs_data !== expv) begin bad++; $display("FAIL write_read_rs got=%h exp=%h", rs_data, expv); end
    expv = exp_q.pop_front(); total++;
    if (rt_data !== expv) begin bad++; $display("FAIL write_read_rt got=%h exp=%h", rt_data, expv); end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h1;
    clock_edge();
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h4444;
    clock_edge();
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hAA; rs_addr = 5'd3; rt_addr = 5'd4;
    #1;
    exp_q.push_back(32'hAA); exp_q.push_back(32'h4444);
    expv = exp_q.pop_front(); total++;
    if (rs_data !== expv) begin bad++; $display("FAIL bypass_rs got=%h exp=%h", rs_data, expv); end
    expv = exp_q.pop_front(); total++;
    if (rt_data !== expv) begin bad++; $display("FAIL bypass_rt_unaffected got=%h exp=%h", rt_data, expv); end
    clock_edge();
  endtask

  task automatic test_link_conflict();
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'h100;
    link_en = 1'b1; link_data = 32'h200; rs_addr = 5'd31; rt_addr = 5'd31;
    #1;
    exp_q.push_back(32'h100); exp_q.push_back(32'h100);
    expv = exp_q.pop_front(); total++;
    if (rs_data !== expv) begin bad++; $display("FAIL conflict_bypass_rs got=%h exp=%h", rs_data, expv); end
    expv = exp_q.pop_front(); total++;
    if (rt_data !== expv) begin bad++; $display("FAIL conflict_bypass_rt got=%h exp=%h", rt_data, expv); end
    clock_edge();
    @(negedge clk);
    idle();
    #1;
    exp_q.push_back(32'h100);
    expv = exp_q.pop_front(); total++;
    if (rs_data !== expv) begin bad++; $display("FAIL conflict_stored got=%h exp=%h", rs_data, expv); end
  endtask

  task automatic test_link_alone();
    @(negedge clk);
    link_en = 1'b1; link_data = 32'h44; rt_addr = 5'd31; rs_addr = 5'd7;
    #1;
    exp_q.push_back(32'h44); exp_q.push_back(32'h1234_5678);
    expv = exp_q.pop_front(); total++;
    if (rt_data !== expv) begin bad++; $display("FAIL link_bypass got=%h exp=%h", rt_data, expv); end
    expv = exp_q.pop_front(); total++;
    if (rs_data !== expv) begin bad++; $display("FAIL link_other_port got=%h exp=%h", rs_data, expv); end
    clock_edge();
    @(negedge clk);
    idle();
    #1;
    exp_q.push_back(32'h44);
    expv = exp_q.pop_front(); total++;
    if (rt_data !== expv) begin bad++; $display("FAIL link_stored got=%h exp=%h", rt_data, expv); end
  endtask

  task automatic test_dbg_latency();
    @(negedge clk);
    dbg_addr = 5'd7; wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h9;
    exp_q.push_back(32'h1234_5678);
    clock_edge();
    expv = exp_q.pop_front(); total++;
    if (dbg_data !== expv) begin bad++; $display("FAIL dbg_old_value got=%h exp=%h", dbg_data, expv); end
    @(negedge clk);
    idle();
    exp_q.push_back(32'h9);
    clock_edge();
    expv = exp_q.pop_front(); total++;
    if (dbg_data !== expv) begin bad++; $display("FAIL dbg_new_value got=%h exp=%h", dbg_data, expv); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      wr_en     = ($urandom_range(0, 2) != 0);
      wr_addr   = 5'($urandom_range(0, 31));
      wr_data   = $urandom;
      link_en   = ($urandom_range(0, 3) == 0);
      link_data = $urandom;
      rs_addr   = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      rt_addr   = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
      dbg_addr  = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) begin
        wr_en = 1'b1; wr_addr = 5'd31; link_en = 1'b1;
      end
      #1;
      exp_q.push_back(model_read(rs_addr));
      exp_q.push_back(model_read(rt_addr));
      expv = exp_q.pop_front(); total++;
      if (rs_data !== expv) begin bad++; $display("FAIL rand_rs i=%0d got=%h exp=%h", i, rs_data, expv); end
      expv = exp_q.pop_front(); total++;
      if (rt_data !== expv) begin bad++; $display("FAIL rand_rt i=%0d got=%h exp=%h", i, rt_data, expv); end
      exp_q.push_back(mdl[dbg_addr]);
      clock_edge();
      expv = exp_q.pop_front(); total++;
      if (dbg_data !== expv) begin bad++; $display("FAIL rand_dbg i=%0d got=%h exp=%h", i, dbg_data, expv); end
    end
  endtask

  task automatic test_sweep();
    @(negedge clk);
    idle();
    for (int a = 0; a < 32; a++) begin
      rs_addr = 5'(a);
      #1;
      exp_q.push_back(mdl[a]);
      expv = exp_q.pop_front(); total++;
      if (rs_data !== expv) begin bad++; $display("FAIL sweep r%0d got=%h exp=%h", a, rs_data, expv); end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    rs_addr = '0; rt_addr = '0; dbg_addr = '0;
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    test_reset();
    test_reset_write_collision();
    test_write_read();
    test_bypass();
    test_link_conflict();
    test_link_alone();
    test_dbg_latency();
    test_random();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the register data width.
REQ-002 The block SHALL have parameter NREG, default 32, giving the register count; addresses SHALL be 5 bits wide and NREG SHALL be 32.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-005 The block SHALL have port rs_addr, input, 5 bits: read port A address.
REQ-006 The block SHALL have port rt_addr, input, 5 bits: read port B address.
REQ-007 The block SHALL have port rs_data, output, DATA_W bits: read port A data.
REQ-008 The block SHALL have port rt_data, output, DATA_W bits: read port B data.
REQ-009 The block SHALL have port wr_en, input, 1 bit: primary write enable.
REQ-010 The block SHALL have port wr_addr, input, 5 bits: primary write address, driven by the upstream 5-bit destination-select mux.
REQ-011 The block SHALL have port wr_data, input, DATA_W bits: primary write data.
REQ-012 The block SHALL have port link_en, input, 1 bit: link write enable, which writes R31.
REQ-013 The block SHALL have port link_data, input, DATA_W bits: return address written to R31.
REQ-014 The block SHALL have port dbg_addr, input, 5 bits: debug read address.
REQ-015 The block SHALL have port dbg_data, output, DATA_W bits: registered debug read data.

Function
REQ-016 Storage SHALL be 32 general registers R0..R31 of DATA_W bits; R0 is an ordinary writable register.
REQ-017 When wr_en=1 at a rising clk edge, R[wr_addr] SHALL be updated to wr_data.
REQ-018 When link_en=1 at a rising clk edge, R31 SHALL be updated to link_data.
REQ-019 When wr_en=1, wr_addr=31 and link_en=1 at the same edge, R31 SHALL take wr_data (primary port wins) and link_data SHALL be discarded.
REQ-020 Writes with the enable low SHALL leave all registers unchanged.
REQ-021 rs_data and rt_data SHALL be combinational (zero-cycle) reads of R[rs_addr] and R[rt_addr].
REQ-022 Bypass: if wr_en=1 and wr_addr equals a read address, that port SHALL output wr_data in the same cycle.
REQ-023 Bypass: if the address is 31, link_en=1, and the primary port is not also writing R31, that port SHALL output link_data.
REQ-024 Bypass priority SHALL follow REQ-019: the primary write beats link, and link beats stored contents.
REQ-025 Both read ports SHALL resolve independently; rs_addr and rt_addr may be equal.
REQ-026 dbg_data SHALL be loaded on each rising edge with R[dbg_addr] as stored before that edge's write, giving 1-cycle latency and no bypass.
REQ-027 No address wrap-around SHALL exist: all 32 codes of a 5-bit address are valid.

Reset
REQ-028 While rst=1, R0..R31 and dbg_data SHALL be 0 immediately, without waiting for clk.
REQ-029 While rst=1, writes SHALL be ignored, bypass SHALL be disabled, and rs_data and rt_data SHALL read 0.
REQ-030 If rst asserts on the same edge as a write, reset SHALL win and the written register SHALL read 0.
REQ-031 After rst deasserts, the first rising edge SHALL perform normal writes.

Verification
REQ-032 Reset sequence: write R5=0xDEADBEEF, then pulse rst mid-cycle -> rs_addr=5 reads 0 with no clock edge and dbg_data=0.
REQ-033 Write then read: wr_en=1, wr_addr=7, wr_data=0x12345678 for one edge -> the next cycle, rs_addr=rt_addr=7 both read 0x12345678.
REQ-034 Same-cycle bypass: R3=0x1 stored, then wr_en=1, wr_addr=3, wr_data=0xAA in the same cycle as rs_addr=3 -> rs_data=0xAA before the edge; rt_addr=4 is unaffected.
REQ-035 Link conflict: wr_en=1, wr_addr=31, wr_data=0x100 together with link_en=1, link_data=0x200 -> R31=0x100 after the edge, and the bypass shows 0x100.
REQ-036 Link alone: link_en=1, link_data=0x44, rt_addr=31 -> rt_data=0x44 in the same cycle and R31=0x44 after the edge.
REQ-037 Debug latency: dbg_addr=7 with a write of 0x9 to R7 on the same edge -> dbg_data shows the old R7 value after that edge and 0x9 one edge later.
